// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the Mini MIPS instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mips_fetch_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;

  // Word address the PC takes on reset unless the instance overrides it.
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches imem[pc] over req/ack and offers it to decode on valid/ready.
// Latency: N+1 cycles per instruction for an N-cycle memory (2 with a combinational memory).
// Backpressure: instr held stable and no new request while decode deasserts instr_ready.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       retired,
  output logic              halted
);

  fetch_state_t      r_state;
  fetch_state_t      w_next_state;
  logic [ADDR_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_pc;
  logic [31:0]       r_retired;

  // State register; reset parks the FSM in IDLE so any late ack is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: redirect wins everywhere, but an outstanding request must still see its ack.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  w_next_state = ST_REQ;
      ST_REQ: begin
        if (imem_ack && !redirect && !r_pend) begin
          w_next_state = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          w_next_state = ST_REQ;
        end else if (instr_ready) begin
          w_next_state = halt ? ST_HALT : ST_REQ;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          w_next_state = ST_REQ;
        end
      end
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // PC, instruction register, deferred-redirect register and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_ack) begin
            // The ack closes the outstanding request, so any deferred redirect is consumed here.
            r_pend <= 1'b0;
            if (redirect) begin
              r_pc <= redirect_pc;
            end else if (r_pend) begin
              r_pc <= r_pend_pc;
            end else begin
              r_instr <= imem_rdata;
            end
          end else if (redirect) begin
            // Cannot abandon the request in flight: remember where to go once it returns.
            r_pend    <= 1'b1;
            r_pend_pc <= redirect_pc;
          end
        end
        ST_VALID: begin
          if (redirect) begin
            r_pc <= redirect_pc;
          end else if (instr_ready) begin
            r_pc      <= next_pc;
            r_retired <= r_retired + 32'd1;
          end
        end
        ST_IDLE, ST_HALT: begin
          if (redirect) begin
            r_pc <= redirect_pc;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode: handshake strobes come straight from the registered state.
  always_comb begin
    imem_req    = (r_state == ST_REQ);
    instr_valid = (r_state == ST_VALID);
    halted      = (r_state == ST_HALT);
    imem_addr   = r_pc;
    pc          = r_pc;
    instr       = r_instr;
    retired     = r_retired;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs. a behavioural model.
// Latency: memory latency is programmable per request (0..3 cycles).
// Backpressure: decode readiness is driven directed or randomly.
module tb_fetch_unit;
  import mips_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] retired;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .retired(retired), .halted(halted)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural view of the fetch stage: what it is doing, not how it is encoded.
  typedef enum {M_BOOT, M_FETCHING, M_OFFERING, M_PARKED} mphase_t;
  mphase_t     m_ph;
  logic [31:0] m_pc, m_instr, m_ret, m_pend_pc;
  bit          m_pend;
  int          lat;
  int          wait_cnt;
  bit          force_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = M_BOOT; m_pc = RPC; m_instr = '0; m_ret = '0;
    m_pend = 0; m_pend_pc = '0; wait_cnt = 0;
  endtask

  task automatic check_all();
    chk("imem_req", imem_req, m_ph == M_FETCHING);
    if (m_ph == M_FETCHING) chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, m_ph == M_OFFERING);
    chk("instr", instr, m_instr);
    chk("pc", pc, m_pc);
    chk("retired", retired, m_ret);
    chk("halted", halted, m_ph == M_PARKED);
  endtask

  // Apply one clock edge's worth of the fetch rules to the model.
  task automatic model_edge(input bit rd, input logic [31:0] rpc, input bit ack,
                            input bit rdy, input bit hlt, input logic [31:0] npc);
    case (m_ph)
      M_BOOT: begin
        if (rd) m_pc = rpc;
        m_ph = M_FETCHING;
      end
      M_FETCHING: begin
        if (ack) begin
          if (rd) begin m_pc = rpc; m_pend = 0; end
          else if (m_pend) begin m_pc = m_pend_pc; m_pend = 0; end
          else begin m_instr = mem_word(m_pc); m_ph = M_OFFERING; end
        end else if (rd) begin
          m_pend = 1; m_pend_pc = rpc;
        end
      end
      M_OFFERING: begin
        if (rd) begin m_pc = rpc; m_ph = M_FETCHING; end
        else if (rdy) begin
          m_pc = npc; m_ret = m_ret + 1;
          m_ph = hlt ? M_PARKED : M_FETCHING;
        end
      end
      M_PARKED: if (rd) begin m_pc = rpc; m_ph = M_FETCHING; end
      default: ;
    endcase
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, advance across the rising edge.
  task automatic cyc(input bit rd, input logic [31:0] rpc, input bit rdy,
                     input bit hlt, input bit jmp);
    logic [31:0] npc;
    bit ack;
    check_all();
    ack = 0;
    if (force_ack) ack = 1;
    else if (m_ph == M_FETCHING) begin
      if (wait_cnt >= lat) begin ack = 1; wait_cnt = 0; end
      else wait_cnt++;
    end
    npc = jmp ? $urandom : m_pc + 32'd1;
    redirect = rd; redirect_pc = rpc; instr_ready = rdy; halt = hlt;
    next_pc = npc; imem_ack = ack;
    imem_rdata = ack ? mem_word(m_pc) : $urandom;
    @(posedge clk);
    model_edge(rd, rpc, ack, rdy, hlt, npc);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; next_pc = '0; redirect = 0; redirect_pc = '0; halt = 0;
    imem_ack = 0; imem_rdata = '0; instr_ready = 0;
    lat = 0; force_ack = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;

    // Combinational memory, decode always ready: 0x10, 0x11, 0x12 every other cycle.
    cyc(0, '0, 1, 0, 0);
    chk("first_addr", imem_addr, 32'h10);
    repeat (6) cyc(0, '0, 1, 0, 0);
    chk("retired_after_6", retired, 32'd3);

    // Three-cycle memory latency.
    lat = 3;
    repeat (16) cyc(0, '0, 1, 0, 0);

    // Decode stalls for 5 cycles while an instruction is offered.
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_ph == M_OFFERING) break;
      cyc(0, '0, 1, 0, 0);
    end
    chk("stall_sync", instr_valid, 1);
    repeat (5) cyc(0, '0, 0, 0, 0);
    chk("stall_no_req", imem_req, 0);
    repeat (4) cyc(0, '0, 1, 0, 0);

    // Two redirects while a 2-cycle request is in flight: last one wins, data dropped.
    lat = 2;
    for (int i = 0; i < 10; i++) begin
      if (m_ph == M_FETCHING && wait_cnt == 0) break;
      cyc(0, '0, 1, 0, 0);
    end
    chk("redir_sync", imem_req, 1);
    cyc(1, 32'h200, 1, 0, 0);
    cyc(1, 32'h300, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("redir_drop_valid", instr_valid, 0);
    chk("redir_addr", imem_addr, 32'h300);
    repeat (6) cyc(0, '0, 1, 0, 0);

    // Halt at acceptance, stay parked, resume at 0x40 on redirect.
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_ph == M_OFFERING) break;
      cyc(0, '0, 1, 0, 0);
    end
    cyc(0, '0, 1, 1, 0);
    chk("halted", halted, 1);
    repeat (6) cyc(0, '0, 1, 1, 0);
    chk("halt_no_req", imem_req, 0);
    cyc(1, 32'h40, 1, 0, 0);
    chk("resume_addr", imem_addr, 32'h40);
    chk("resume_req", imem_req, 1);
    repeat (3) cyc(0, '0, 1, 0, 0);

    // Redirect and ready in the same offering cycle: nothing retires.
    for (int i = 0; i < 10; i++) begin
      if (m_ph == M_OFFERING) break;
      cyc(0, '0, 1, 0, 0);
    end
    cyc(1, 32'h80, 1, 0, 0);
    chk("rr_pc", pc, 32'h80);

    // PC wraps from 0xFFFFFFFF to 0.
    cyc(0, '0, 1, 0, 0);
    cyc(1, 32'hFFFF_FFFF, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", imem_req, 1);

    // Reset asserted mid-request; a late ack while in IDLE is ignored.
    lat = 3;
    for (int i = 0; i < 10; i++) begin
      if (m_ph == M_FETCHING && wait_cnt == 0) break;
      cyc(0, '0, 1, 0, 0);
    end
    cyc(0, '0, 1, 0, 0);
    #2 rst_n = 0;
    imem_ack = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1;
    force_ack = 1;
    cyc(0, '0, 1, 0, 0);
    force_ack = 0;
    chk("post_reset_addr", imem_addr, RPC);
    repeat (8) cyc(0, '0, 1, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      bit rd;
      if (m_ph != M_FETCHING && $urandom_range(0, 3) == 0) lat = $urandom_range(0, 3);
      rd = (m_ph == M_PARKED) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 19) == 0);
      cyc(rd, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 3);
    end
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
